// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, prioritised
// hazard events and the per-event control-signal encoding.
package pipeline_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_LD_STALL  = 2'd1,
        ST_DMEM_WAIT = 2'd2
    } hz_state_e;

    // Listed lowest to highest priority.
    typedef enum logic [2:0] {
        EV_NONE      = 3'd0,
        EV_IMEM_WAIT = 3'd1,
        EV_LOAD_USE  = 3'd2,
        EV_BRANCH    = 3'd3,
        EV_DMEM_WAIT = 3'd4
    } hz_event_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic pipe_hold;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_DEFAULT = '{pc_write: 1'b1, if_id_write: 1'b1,
                                          if_id_flush: 1'b0, id_ex_flush: 1'b0,
                                          pipe_hold: 1'b0};

    function automatic hz_event_e pick_event(input logic dmem_wait, input logic branch,
                                             input logic load_use, input logic imem_wait);
        if (dmem_wait)     return EV_DMEM_WAIT;
        else if (branch)   return EV_BRANCH;
        else if (load_use) return EV_LOAD_USE;
        else if (imem_wait) return EV_IMEM_WAIT;
        else               return EV_NONE;
    endfunction

    function automatic hz_ctrl_t event_ctrl(input hz_event_e ev);
        hz_ctrl_t c;
        c = CTRL_DEFAULT;
        case (ev)
            EV_DMEM_WAIT: begin
                c.pc_write    = 1'b0;
                c.if_id_write = 1'b0;
                c.pipe_hold   = 1'b1;
            end
            EV_BRANCH: begin
                c.if_id_flush = 1'b1;
                c.id_ex_flush = 1'b1;
            end
            EV_LOAD_USE: begin
                c.pc_write    = 1'b0;
                c.if_id_write = 1'b0;
                c.id_ex_flush = 1'b1;
            end
            // Fetch bubble: IF/ID takes a NOP while the rest of the pipe drains.
            EV_IMEM_WAIT: begin
                c.pc_write    = 1'b0;
                c.if_id_flush = 1'b1;
            end
            default: c = CTRL_DEFAULT;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bus: pipeline status in, stall/flush enables and
// performance counters out.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             branch_taken;
    logic             imem_ready;
    logic             mem_access;
    logic             dmem_ready;

    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             pipe_hold;
    logic [CNT_W-1:0] load_stall_cnt;
    logic [CNT_W-1:0] branch_flush_cnt;
    logic [CNT_W-1:0] mem_wait_cnt;
    logic             err_timeout;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
               branch_taken, imem_ready, mem_access, dmem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold,
               load_stall_cnt, branch_flush_cnt, mem_wait_cnt, err_timeout
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
               branch_taken, imem_ready, mem_access, dmem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold,
               load_stall_cnt, branch_flush_cnt, mem_wait_cnt, err_timeout
    );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);
    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) cnt_d = cnt_q + WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: same-cycle stall/flush decisions with fixed
// priority, one-bubble load-use FSM, data-memory timeout and event counters.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           reset,
    hazard_ctrl_if.slave   hz
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    hz_state_e         state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;

    logic      dmem_wait, load_use_raw, load_use;
    hz_event_e ev;
    hz_ctrl_t  ctrl;

    always_comb begin
        dmem_wait    = hz.mem_access & ~hz.dmem_ready;
        load_use_raw = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                       ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                        (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));
        // The bubble already inserted for this load covers the dependency.
        load_use     = load_use_raw && (state_q != ST_LD_STALL);
        ev           = pick_event(dmem_wait, hz.branch_taken, load_use, ~hz.imem_ready);
        if (reset) ev = EV_NONE;
        ctrl         = event_ctrl(ev);

        case (ev)
            EV_DMEM_WAIT: state_d = ST_DMEM_WAIT;
            EV_LOAD_USE:  state_d = ST_LD_STALL;
            default:      state_d = ST_RUN;
        endcase

        wait_cnt_d = '0;
        err_d      = err_q;
        if (ev == EV_DMEM_WAIT) begin
            wait_cnt_d = (wait_cnt_q == WAIT_W'(TIMEOUT)) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
            // wait_cnt_q counts earlier wait cycles, so this is the TIMEOUT-th one.
            if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign hz.pc_write    = ctrl.pc_write;
    assign hz.if_id_write = ctrl.if_id_write;
    assign hz.if_id_flush = ctrl.if_id_flush;
    assign hz.id_ex_flush = ctrl.id_ex_flush;
    assign hz.pipe_hold   = ctrl.pipe_hold;
    assign hz.err_timeout = err_q;

    sat_counter #(.WIDTH(CNT_W)) u_load_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ev == EV_LOAD_USE),
        .cnt   (hz.load_stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_branch_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ev == EV_BRANCH),
        .cnt   (hz.branch_flush_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_mem_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ev == EV_DMEM_WAIT),
        .cnt   (hz.mem_wait_cnt)
    );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected results,
// a negedge monitor pops and compares.
module tb_hazard_ctrl;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 255;

    // {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold}
    localparam logic [4:0] C_DEF  = 5'b11000;
    localparam logic [4:0] C_DMEM = 5'b00001;
    localparam logic [4:0] C_BR   = 5'b11110;
    localparam logic [4:0] C_LU   = 5'b00010;
    localparam logic [4:0] C_IM   = 5'b01100;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       imr;
        logic       ma;
        logic       dr;
    } vec_t;

    typedef struct {
        logic [4:0]       ctl;
        logic [CNT_W-1:0] ls;
        logic [CNT_W-1:0] bf;
        logic [CNT_W-1:0] mw;
        logic             err;
        string            nm;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (bus.slave)
    );

    exp_t             sb[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [CNT_W-1:0] e_ls, e_bf, e_mw;
    logic             e_err;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
    endfunction

    task automatic drive(input vec_t v);
        bus.id_rs1       = v.rs1;
        bus.id_rs2       = v.rs2;
        bus.id_uses_rs1  = v.u1;
        bus.id_uses_rs2  = v.u2;
        bus.ex_mem_read  = v.mr;
        bus.ex_rd        = v.rd;
        bus.branch_taken = v.br;
        bus.imem_ready   = v.imr;
        bus.mem_access   = v.ma;
        bus.dmem_ready   = v.dr;
    endtask

    // One cycle: drive, queue the expectation, then apply the expected
    // counter/flag effects of this cycle's clock edge.
    task automatic step(input vec_t v, input logic rst, input logic [4:0] ctl,
                        input logic ils, input logic ibf, input logic imw,
                        input logic set_err, input string nm);
        exp_t e;
        reset = rst;
        drive(v);
        e.ctl = ctl; e.ls = e_ls; e.bf = e_bf; e.mw = e_mw; e.err = e_err; e.nm = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (rst) begin
            e_ls = '0; e_bf = '0; e_mw = '0; e_err = 1'b0;
        end else begin
            e_ls  = sat_inc(e_ls, ils);
            e_bf  = sat_inc(e_bf, ibf);
            e_mw  = sat_inc(e_mw, imw);
            e_err = e_err | set_err;
        end
    endtask

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h expected %0h at %0t", nm, fld, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.nm, "ctl", 32'({bus.pc_write, bus.if_id_write, bus.if_id_flush,
                                  bus.id_ex_flush, bus.pipe_hold}), 32'(e.ctl));
            chk(e.nm, "load_stall_cnt",   32'(bus.load_stall_cnt),   32'(e.ls));
            chk(e.nm, "branch_flush_cnt", 32'(bus.branch_flush_cnt), 32'(e.bf));
            chk(e.nm, "mem_wait_cnt",     32'(bus.mem_wait_cnt),     32'(e.mw));
            chk(e.nm, "err_timeout",      32'(bus.err_timeout),      32'(e.err));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t idle, lu1, v;
        idle = '0; idle.imr = 1'b1;
        lu1  = idle; lu1.rs1 = 5'd5; lu1.u1 = 1'b1; lu1.mr = 1'b1; lu1.rd = 5'd5;
        e_ls = '0; e_bf = '0; e_mw = '0; e_err = 1'b0;
        reset = 1'b1;
        drive(idle);
        @(posedge clk);
        #1;

        // Reset forces default controls even with every hazard present
        v = lu1; v.br = 1'b1; v.ma = 1'b1; v.dr = 1'b0; v.imr = 1'b0;
        step(v,    1, C_DEF, 0, 0, 0, 0, "reset_dflt");
        step(idle, 0, C_DEF, 0, 0, 0, 0, "idle");

        // Load-use on rs1: exactly one bubble
        step(lu1,  0, C_LU,  1, 0, 0, 0, "lu_c0");
        step(lu1,  0, C_DEF, 0, 0, 0, 0, "lu_c1");
        step(idle, 0, C_DEF, 0, 0, 0, 0, "lu_after");

        // x0 destination never stalls
        v = lu1; v.rd = 5'd0; v.rs1 = 5'd0;
        step(v, 0, C_DEF, 0, 0, 0, 0, "rd0_nostall");
        step(v, 0, C_DEF, 0, 0, 0, 0, "rd0_hold");

        // rs2 match only counts when rs2 is actually read
        v = lu1; v.u1 = 1'b0; v.rs2 = 5'd5;
        step(v, 0, C_DEF, 0, 0, 0, 0, "rs2_unused");
        v.u2 = 1'b1;
        step(v,    0, C_LU,  1, 0, 0, 0, "rs2_lu");
        step(idle, 0, C_DEF, 0, 0, 0, 0, "rs2_after");
        v = lu1; v.mr = 1'b0;
        step(v, 0, C_DEF, 0, 0, 0, 0, "not_load");

        // Branch beats load-use
        v = lu1; v.br = 1'b1;
        step(v,    0, C_BR,  0, 1, 0, 0, "br_over_lu");
        step(idle, 0, C_DEF, 0, 0, 0, 0, "br_after");

        // Instruction-memory wait, and load-use beating it
        v = idle; v.imr = 1'b0;
        step(v, 0, C_IM, 0, 0, 0, 0, "imem_wait");
        v = lu1; v.imr = 1'b0;
        step(v, 0, C_LU, 1, 0, 0, 0, "lu_over_imem");
        v = idle; v.imr = 1'b0;
        step(v, 0, C_IM, 0, 0, 0, 0, "imem_in_ldstall");

        // Data-memory wait beats branch for 3 cycles
        v = idle; v.br = 1'b1; v.ma = 1'b1; v.dr = 1'b0;
        for (int i = 0; i < 3; i++) step(v, 0, C_DMEM, 0, 0, 1, 0, "dmem_over_br");
        v.dr = 1'b1;
        step(v,    0, C_BR,  0, 1, 0, 0, "br_after_dmem");
        step(idle, 0, C_DEF, 0, 0, 0, 0, "idle2");

        // Data-memory wait beats load-use, then the load-use gets its single bubble
        v = lu1; v.ma = 1'b1;
        step(v, 0, C_DMEM, 0, 0, 1, 0, "dmem_over_lu");
        v.ma = 1'b0;
        step(v, 0, C_LU,  1, 0, 0, 0, "lu_after_dmem");
        step(v, 0, C_DEF, 0, 0, 0, 0, "lu_once");

        // 256-cycle wait: flag visible from cycle 255, counter saturates
        v = idle; v.ma = 1'b1;
        for (int k = 0; k < 256; k++) step(v, 0, C_DMEM, 0, 0, 1, (k == TIMEOUT - 1), "timeout_wait");
        v.dr = 1'b1;
        for (int i = 0; i < 3; i++) step(v, 0, C_DEF, 0, 0, 0, 0, "err_sticky");

        // Reset in the middle of a data-memory wait
        v = idle; v.ma = 1'b1;
        step(v, 0, C_DMEM, 0, 0, 1, 0, "pre_rst_wait");
        step(v, 0, C_DMEM, 0, 0, 1, 0, "pre_rst_wait");
        step(v,    1, C_DEF, 0, 0, 0, 0, "rst_in_dmem");
        step(lu1,  0, C_LU,  1, 0, 0, 0, "fresh_after_rst");
        step(idle, 0, C_DEF, 0, 0, 0, 0, "post_rst_idle");

        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
